vending_machine_param: RTL
==========================

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL have parameter PRICE, default 3, item price in 5-rs units; legal range 1 <= PRICE <= 2^CREDIT_W-3.
REQ-002 SHALL have parameter CREDIT_W, default 4, credit register width in 5-rs units.
REQ-003 SHALL have parameter STOCK_W, default 4, stock counter width.
REQ-004 SHALL have parameter STOCK_INIT, default 8, stock loaded at reset and on restock; legal range 1 <= STOCK_INIT <= 2^STOCK_W-1.
REQ-005 SHALL have port clk, input, 1 bit, single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit; one clock, reset asynchronous and active-high.
REQ-007 SHALL have port in, input, 2 bits, coin code sampled each edge: 00 none, 01 5 rs, 10 10 rs, 11 invalid.
REQ-008 SHALL have port cancel, input, 1 bit, refund request.
REQ-009 SHALL have port restock, input, 1 bit, reload stock.
REQ-010 SHALL have port vend_ready, input, 1 bit, dispenser accepts item.
REQ-011 SHALL have port out, output, 1 bit, dispense request, level.
REQ-012 SHALL have port change, output, 2 bits, change coin strobe: 00 none, 01 5 rs, 10 10 rs.
REQ-013 SHALL have port credit, output, CREDIT_W bits, current credit.
REQ-014 SHALL have port stock, output, STOCK_W bits, items remaining.
REQ-015 SHALL have port coin_reject, output, 1 bit, one-cycle pulse when a coin is returned unaccepted.
REQ-016 SHALL have port sold_out, output, 1 bit, high in SOLDOUT.

Function
REQ-017 All outputs SHALL be registered; a sampled input affects outputs after the same edge.
REQ-018 FSM states SHALL be IDLE, COLLECT, VEND, CHANGE, SOLDOUT.
REQ-019 IDLE/COLLECT: a valid coin SHALL add 1 (01) or 2 (10) to credit; if new credit >= PRICE go to VEND, else COLLECT.
REQ-020 COLLECT with cancel=1 SHALL go to CHANGE with credit unchanged; a coin sampled in the same cycle SHALL be rejected (cancel wins).
REQ-021 cancel in IDLE SHALL be ignored.
REQ-022 Code 11 in any state, and any nonzero code in VEND, CHANGE or SOLDOUT, SHALL pulse coin_reject for one cycle with credit unchanged.
REQ-023 VEND: out SHALL be held high until an edge with out=1 and vend_ready=1; on that edge out falls, stock decrements, credit -= PRICE.
REQ-024 After the VEND handshake the FSM SHALL go to CHANGE if the remaining credit > 0; otherwise to SOLDOUT if stock became 0, else IDLE.
REQ-025 cancel in VEND SHALL be ignored.
REQ-026 CHANGE SHALL emit one coin per cycle: 10 with credit -= 2 if credit >= 2, else 01 with credit -= 1.
REQ-027 change SHALL be 00 in every other cycle.
REQ-028 When credit reaches 0 in CHANGE, the next state SHALL be SOLDOUT if stock = 0, else IDLE.
REQ-029 SOLDOUT: restock=1 SHALL load stock = STOCK_INIT and go to IDLE.
REQ-030 restock SHALL be ignored in all other states.
REQ-031 The credit limit in REQ-001 SHALL guarantee no credit overflow; credit SHALL never go below 0.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, credit 0, stock STOCK_INIT, and out, change, coin_reject, sold_out 0, including mid-VEND or mid-CHANGE.
REQ-033 Credit held at reset SHALL be discarded without any change strobe.

Verification (PRICE=3, STOCK_INIT=2)
REQ-034 in 01 then 10 -> credit 1 then 3, out=1; vend_ready high 2 cycles later -> out=0, stock 1, IDLE, no change.
REQ-035 in 10, 10 -> credit 4, out=1; after handshake -> credit 1, change=01 for one cycle, then IDLE with credit 0.
REQ-036 in 10 then cancel -> change=10 for one cycle, credit 0, IDLE; cancel together with in=01 -> coin_reject pulse and refund of prior credit only.
REQ-037 in=11, or any coin during VEND -> coin_reject=1 for one cycle, credit unchanged.
REQ-038 Two sales -> stock 0, sold_out=1, in=01 rejected; restock -> sold_out=0, stock 2, IDLE.
REQ-039 rst asserted between edges while out=1 -> out, credit and change 0 with no clock edge; stock 2.

Source files
------------

// File: rtl/vending_machine_param.sv
// Parameterised coin-operated vending controller: accumulates 5/10 rs coins,
// dispenses one item over a ready handshake, returns change and tracks stock.
module vending_machine_param #(
  parameter int PRICE      = 3,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic                cancel,
  input  logic                restock,
  input  logic                vend_ready,
  output logic                out,
  output logic [1:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                coin_reject,
  output logic                sold_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_SOLDOUT = 3'd4
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
  localparam logic [STOCK_W-1:0]  STOCK_INIT_C = STOCK_W'(STOCK_INIT);
  localparam logic [CREDIT_W-1:0] CREDIT_ZERO  = CREDIT_W'(0);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] CREDIT_TWO   = CREDIT_W'(2);
  localparam logic [STOCK_W-1:0]  STOCK_ZERO   = STOCK_W'(0);
  localparam logic [STOCK_W-1:0]  STOCK_ONE    = STOCK_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_next;
  logic [STOCK_W-1:0]  r_stock;
  logic [STOCK_W-1:0]  w_stock_next;
  logic                r_out;
  logic                w_out_next;
  logic [1:0]          r_change;
  logic [1:0]          w_change_next;
  logic                r_coin_reject;
  logic                w_coin_reject_next;
  logic                r_sold_out;
  logic                w_sold_out_next;
  logic                w_coin_ok;
  logic [CREDIT_W-1:0] w_coin_val;

  assign w_coin_ok  = (in == 2'b01) || (in == 2'b10);
  assign w_coin_val = CREDIT_W'(in);

  // State, datapath and output registers; reset discards any held credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_credit      <= CREDIT_ZERO;
      r_stock       <= STOCK_INIT_C;
      r_out         <= 1'b0;
      r_change      <= 2'b00;
      r_coin_reject <= 1'b0;
      r_sold_out    <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_credit      <= w_credit_next;
      r_stock       <= w_stock_next;
      r_out         <= w_out_next;
      r_change      <= w_change_next;
      r_coin_reject <= w_coin_reject_next;
      r_sold_out    <= w_sold_out_next;
    end
  end

  // Next-state, credit and stock update.
  always_comb begin
    w_next_state  = r_state;
    w_credit_next = r_credit;
    w_stock_next  = r_stock;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if ((r_state == S_COLLECT) && cancel) begin
          w_next_state = S_CHANGE;
        end else if (w_coin_ok) begin
          w_credit_next = r_credit + w_coin_val;
          if (w_credit_next >= PRICE_C) begin
            w_next_state = S_VEND;
          end else begin
            w_next_state = S_COLLECT;
          end
        end else begin
          w_next_state = r_state;
        end
      end
      S_VEND: begin
        if (r_out && vend_ready) begin
          w_credit_next = r_credit - PRICE_C;
          w_stock_next  = r_stock - STOCK_ONE;
          if (w_credit_next != CREDIT_ZERO) begin
            w_next_state = S_CHANGE;
          end else if (w_stock_next == STOCK_ZERO) begin
            w_next_state = S_SOLDOUT;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_VEND;
        end
      end
      S_CHANGE: begin
        if (r_credit >= CREDIT_TWO) begin
          w_credit_next = r_credit - CREDIT_TWO;
        end else if (r_credit != CREDIT_ZERO) begin
          w_credit_next = r_credit - CREDIT_ONE;
        end else begin
          w_credit_next = r_credit;
        end
        if (w_credit_next != CREDIT_ZERO) begin
          w_next_state = S_CHANGE;
        end else if (r_stock == STOCK_ZERO) begin
          w_next_state = S_SOLDOUT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SOLDOUT: begin
        if (restock) begin
          w_stock_next = STOCK_INIT_C;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_SOLDOUT;
        end
      end
      default: begin
        w_next_state  = S_IDLE;
        w_credit_next = CREDIT_ZERO;
        w_stock_next  = STOCK_INIT_C;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_out_next         = (w_next_state == S_VEND);
    w_sold_out_next    = (w_next_state == S_SOLDOUT);
    w_change_next      = 2'b00;
    w_coin_reject_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_coin_reject_next = (in == 2'b11);
      end
      S_COLLECT: begin
        w_coin_reject_next = (in == 2'b11) || (cancel && (in != 2'b00));
      end
      S_VEND, S_SOLDOUT: begin
        w_coin_reject_next = (in != 2'b00);
      end
      S_CHANGE: begin
        w_coin_reject_next = (in != 2'b00);
        if (r_credit >= CREDIT_TWO) begin
          w_change_next = 2'b10;
        end else if (r_credit != CREDIT_ZERO) begin
          w_change_next = 2'b01;
        end else begin
          w_change_next = 2'b00;
        end
      end
      default: begin
        w_coin_reject_next = 1'b0;
      end
    endcase
  end

  assign out         = r_out;
  assign change      = r_change;
  assign credit      = r_credit;
  assign stock       = r_stock;
  assign coin_reject = r_coin_reject;
  assign sold_out    = r_sold_out;

endmodule
